// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the video timing generator.
//   - sync_pol_e  : active level of a sync output
//   - VGA_*       : default 640x480@60 timing (800 x 525 total, 25.175 MHz pixel clock)
//   - axis_total  : total pixels/lines of one axis from its four segments
package video_timing_gen_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam sync_pol_e VGA_HSYNC_POL = SYNC_ACTIVE_LOW;
    localparam sync_pol_e VGA_VSYNC_POL = SYNC_ACTIVE_LOW;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bundle between the timing generator and its consumer.
//   ce          : pixel enable into the generator
//   hsync/vsync : registered syncs at the configured polarity
//   display_on  : inside the visible area
//   hpos/vpos   : current pixel / line counters (CW bits)
//   line_start  : one-clk pulse at the start of each line
//   frame_start : one-clk pulse at the start of each frame
//   frame_count : 8-bit frame counter (zero unless the counter is built in)
// master = generator side, slave = consumer side.
interface video_timing_gen_if #(
    parameter int CW = 10
);
    logic          ce;
    logic          hsync;
    logic          vsync;
    logic          display_on;
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_count;

    modport master (
        input  ce,
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
    );

    modport slave (
        output ce,
        input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vtg_axis_counter.sv
// One timing axis: a counter that wraps TOTAL-1 -> 0 plus a registered sync
// window compare.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance the counter (and re-evaluate sync) this cycle
//   pos        : current count
//   wrap       : pos is at its terminal value (TOTAL-1); not gated by en
//   sync       : POL while the pre-advance count was in [ACTIVE+FP, ACTIVE+FP+SYNC)
module vtg_axis_counter
    import video_timing_gen_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] pos,
    output logic          wrap,
    output logic          sync
);
    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    logic in_win;

    assign wrap   = (pos == CW'(TOTAL - 1));
    // Compare in int so a window ending exactly at 2^CW does not truncate.
    assign in_win = (int'(pos) >= SYNC_START) && (int'(pos) < SYNC_END);

    // Sync is computed from the count before it advances, so it trails the
    // counter by one enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos  <= '0;
            sync <= ~POL;
        end else if (en) begin
            pos  <= wrap ? '0 : pos + CW'(1);
            sync <= in_win ? POL : ~POL;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (default 640x480@60).
//   clk, reset : clock, synchronous active-high reset (wins over ce)
//   vid        : video_timing_gen_if master (ce in; syncs, positions, pulses out)
// Horizontal counter advances on every ce; vertical counter and vsync advance
// on the ce that wraps the line. line_start/frame_start are registered pulses
// in the cycle after the wrapping ce.
// Build option: define VTG_FRAME_COUNT_EN to include the 8-bit frame counter;
// otherwise frame_count is tied to 0.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = bit'(VGA_HSYNC_POL),
    parameter bit VSYNC_POL = bit'(VGA_VSYNC_POL),
    parameter int CW        = 10
) (
    input  logic               clk,
    input  logic               reset,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2 ** CW) begin : g_h_total_chk
        $error("video_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > 2 ** CW) begin : g_v_total_chk
        $error("video_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic h_wrap;
    logic v_wrap;
    logic v_en;     // ce that ends a line
    logic f_end;    // ce that ends a frame

    assign v_en  = vid.ce & h_wrap;
    assign f_end = v_en & v_wrap;

    vtg_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL),
        .CW     (CW)
    ) u_h_cnt (
        .clk    (clk),
        .reset  (reset),
        .en     (vid.ce),
        .pos    (vid.hpos),
        .wrap   (h_wrap),
        .sync   (vid.hsync)
    );

    vtg_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL),
        .CW     (CW)
    ) u_v_cnt (
        .clk    (clk),
        .reset  (reset),
        .en     (v_en),
        .pos    (vid.vpos),
        .wrap   (v_wrap),
        .sync   (vid.vsync)
    );

    assign vid.display_on = (vid.hpos < CW'(H_ACTIVE)) && (vid.vpos < CW'(V_ACTIVE));

    // Pulses are one clk wide by construction: the wrapping ce only lasts a
    // cycle and the counter has left its terminal value afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.line_start  <= v_en;
            vid.frame_start <= f_end;
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    logic [7:0] frame_cnt;

    // Steps on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (f_end) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vid.frame_count = frame_cnt;
`else
    assign vid.frame_count = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a default 640x480 instance and a tiny
// high-polarity instance (24 x 8 raster) run side by side. A reference model
// pushes the expected outputs for every clk into a queue; the queue is popped
// and compared half a clock later. Directed measurements (sync windows,
// periods, display counts, reset behaviour, frame counter wrap) run alongside.
module tb_video_timing_gen;
    import video_timing_gen_pkg::*;

    localparam int CW = 10;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int h, v;
        bit hs, vs, de, ls, fs;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(CW)) vif_d ();
    video_timing_gen_if #(.CW(CW)) vif_s ();

    video_timing_gen #(.CW(CW)) dut_d (
        .clk   (clk),
        .reset (reset),
        .vid   (vif_d)
    );

    video_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CW (CW)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .vid   (vif_s)
    );

    cfg_t cfg_d, cfg_s;
    exp_t m_d, m_s;
    exp_t q_d[$];
    exp_t q_s[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  ce_v, rst_v;
    int  ncyc = 0;
    int  exp_div = 1;
    // measurement state
    bit  hfall_ok_d, line_ok_d, hrise_ok_s, fr_ok_s;
    int  last_hfall_d, last_hrise_s, last_fs_s, de_cnt_d, de_cnt_s, nframes;
    logic prev_hs_d, prev_hs_s, prev_ls_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_step(input exp_t s, input cfg_t c, input bit ce_i, input bit rst_i);
        exp_t n;
        int ht, vt, hws, vws;
        bit hw;
        n   = s;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        vt  = c.va + c.vf + c.vsw + c.vb;
        hws = c.ha + c.hf;
        vws = c.va + c.vf;
        if (rst_i) begin
            n.h = 0; n.v = 0; n.hs = !c.hp; n.vs = !c.vp;
            n.ls = 0; n.fs = 0; n.fc = 0;
        end else begin
            hw   = ce_i && (s.h == ht - 1);
            n.ls = hw;
            n.fs = hw && (s.v == vt - 1);
            if (ce_i) begin
                n.h  = hw ? 0 : s.h + 1;
                n.hs = (s.h >= hws && s.h < hws + c.hsw) ? c.hp : !c.hp;
            end
            if (hw) begin
                n.v  = (s.v == vt - 1) ? 0 : s.v + 1;
                n.vs = (s.v >= vws && s.v < vws + c.vsw) ? c.vp : !c.vp;
            end
`ifdef VTG_FRAME_COUNT_EN
            if (n.fs) n.fc = (s.fc + 1) % 256;
`endif
        end
        n.de = (n.h < c.ha) && (n.v < c.va);
        return n;
    endfunction

    task automatic clear_meas();
        hfall_ok_d = 0; line_ok_d = 0; hrise_ok_s = 0; fr_ok_s = 0;
        de_cnt_d = 0; de_cnt_s = 0;
    endtask

    // One clock: drive inputs, model the edge, compare at the falling edge.
    task automatic cyc();
        exp_t e;
        vif_d.ce = ce_v;
        vif_s.ce = ce_v;
        reset    = rst_v;
        @(posedge clk);
        m_d = model_step(m_d, cfg_d, ce_v, rst_v);
        m_s = model_step(m_s, cfg_s, ce_v, rst_v);
        q_d.push_back(m_d);
        q_s.push_back(m_s);
        @(negedge clk);
        ncyc++;
        e = q_d.pop_front();
        chk("d_hpos", 32'(vif_d.hpos), e.h);
        chk("d_vpos", 32'(vif_d.vpos), e.v);
        chk("d_hsync", 32'(vif_d.hsync), 32'(e.hs));
        chk("d_vsync", 32'(vif_d.vsync), 32'(e.vs));
        chk("d_display_on", 32'(vif_d.display_on), 32'(e.de));
        chk("d_line_start", 32'(vif_d.line_start), 32'(e.ls));
        chk("d_frame_start", 32'(vif_d.frame_start), 32'(e.fs));
        chk("d_frame_count", 32'(vif_d.frame_count), e.fc);
        e = q_s.pop_front();
        chk("s_hpos", 32'(vif_s.hpos), e.h);
        chk("s_vpos", 32'(vif_s.vpos), e.v);
        chk("s_hsync", 32'(vif_s.hsync), 32'(e.hs));
        chk("s_vsync", 32'(vif_s.vsync), 32'(e.vs));
        chk("s_display_on", 32'(vif_s.display_on), 32'(e.de));
        chk("s_line_start", 32'(vif_s.line_start), 32'(e.ls));
        chk("s_frame_start", 32'(vif_s.frame_start), 32'(e.fs));
        chk("s_frame_count", 32'(vif_s.frame_count), e.fc);

        if (rst_v) begin
            clear_meas();
            nframes = 0;
        end else begin
            // default instance: hsync window, period, display per line, pulse width
            if (vif_d.hsync === 1'b0)
                chk("d_hs_window", 32'(vif_d.hpos >= 657 && vif_d.hpos <= 752), 1);
            if (prev_hs_d === 1'b1 && vif_d.hsync === 1'b0) begin
                if (hfall_ok_d) chk("d_hs_period", ncyc - last_hfall_d, exp_div * 800);
                last_hfall_d = ncyc;
                hfall_ok_d   = 1;
            end
            if (vif_d.line_start === 1'b1) begin
                chk("d_ls_width", 32'(prev_ls_d), 0);
                if (line_ok_d) chk("d_de_per_line", de_cnt_d, exp_div * 640);
                line_ok_d = 1;
                de_cnt_d  = 0;
            end
            if (vif_d.display_on === 1'b1) de_cnt_d++;
            // small instance: high-polarity windows, periods, display per frame
            if (vif_s.hsync === 1'b1)
                chk("s_hs_window", 32'(vif_s.hpos >= 19 && vif_s.hpos <= 21), 1);
            if (vif_s.vsync === 1'b1)
                chk("s_vs_window", 32'(vif_s.vpos >= 6 && vif_s.vpos <= 7), 1);
            if (prev_hs_s === 1'b0 && vif_s.hsync === 1'b1) begin
                if (hrise_ok_s) chk("s_hs_period", ncyc - last_hrise_s, exp_div * 24);
                last_hrise_s = ncyc;
                hrise_ok_s   = 1;
            end
            if (vif_s.frame_start === 1'b1) begin
                chk("s_fs_with_ls", 32'(vif_s.line_start), 1);
                if (fr_ok_s) begin
                    chk("s_fs_period", ncyc - last_fs_s, exp_div * 192);
                    chk("s_de_per_frame", de_cnt_s, exp_div * 64);
                end
                last_fs_s = ncyc;
                fr_ok_s   = 1;
                de_cnt_s  = 0;
                nframes++;
            end
            if (vif_s.display_on === 1'b1) de_cnt_s++;
        end
        prev_hs_d = vif_d.hsync;
        prev_hs_s = vif_s.hsync;
        prev_ls_d = vif_d.line_start;
    endtask

    initial begin
        bit found;
        int fc_exp_255, fc_exp_1;
        cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg_s = '{16, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1};
        m_d = '{default: 0};
        m_s = '{default: 0};
        clear_meas();
        nframes = 0;
`ifdef VTG_FRAME_COUNT_EN
        fc_exp_255 = 255;
        fc_exp_1   = 1;
`else
        fc_exp_255 = 0;
        fc_exp_1   = 0;
`endif

        // reset state
        rst_v = 1; ce_v = 1;
        repeat (3) cyc();
        chk("rst_d_hpos", 32'(vif_d.hpos), 0);
        chk("rst_d_vpos", 32'(vif_d.vpos), 0);
        chk("rst_d_hsync", 32'(vif_d.hsync), 1);
        chk("rst_d_vsync", 32'(vif_d.vsync), 1);
        chk("rst_s_hsync", 32'(vif_s.hsync), 0);
        chk("rst_s_vsync", 32'(vif_s.vsync), 0);
        chk("rst_d_pulses", 32'({vif_d.line_start, vif_d.frame_start}), 0);
        chk("rst_d_frame_count", 32'(vif_d.frame_count), 0);

        // continuous ce
        rst_v = 0; exp_div = 1;
        repeat (1700) cyc();

        // ce toggling: every period doubles
        clear_meas(); exp_div = 2;
        for (int i = 0; i < 3400; i++) begin
            ce_v = ~ce_v;
            cyc();
        end

        // reset mid-frame on the small raster (hpos 10, line 3)
        ce_v = 1; clear_meas(); exp_div = 1;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (vif_s.hpos == 10 && vif_s.vpos == 3) found = 1;
            else cyc();
        end
        chk("s_reach_mid_frame", 32'(found), 1);
        rst_v = 1;
        cyc();
        chk("midrst_s_pos", 32'({vif_s.hpos, vif_s.vpos}), 0);
        chk("midrst_d_pos", 32'({vif_d.hpos, vif_d.vpos}), 0);
        chk("midrst_s_syncs", 32'({vif_s.hsync, vif_s.vsync}), 0);
        chk("midrst_d_syncs", 32'({vif_d.hsync, vif_d.vsync}), 3);
        rst_v = 0;
        cyc();
        chk("midrst_s_pulses", 32'({vif_s.line_start, vif_s.frame_start}), 0);
        chk("midrst_d_pulses", 32'({vif_d.line_start, vif_d.frame_start}), 0);
        chk("midrst_s_hpos_next", 32'(vif_s.hpos), 1);

        // 257 frames on the small raster: frame counter wraps
        for (int i = 0; i < 60000 && nframes < 257; i++) begin
            cyc();
            if (vif_s.frame_start === 1'b1 && nframes == 255)
                chk("s_fc_at_255", 32'(vif_s.frame_count), fc_exp_255);
            if (vif_s.frame_start === 1'b1 && nframes == 256)
                chk("s_fc_wrap_0", 32'(vif_s.frame_count), 0);
        end
        chk("s_frames_seen", nframes, 257);
        chk("s_fc_after_257", 32'(vif_s.frame_count), fc_exp_1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HSYNC_POL, default 0, active level of hsync (0 = active-low).
REQ-010 SHALL have parameter VSYNC_POL, default 0, active level of vsync.
REQ-011 SHALL have parameter CW, default 10, counter and position width.
REQ-012 SHALL have ports: clk input 1, clock; reset input 1, synchronous active-high reset.
REQ-013 SHALL have port ce input 1, pixel enable; all timing advances only when ce=1.
REQ-014 SHALL have ports hsync output 1 and vsync output 1, registered syncs at the configured polarity.
REQ-015 SHALL have port display_on output 1, high inside the active area.
REQ-016 SHALL have ports hpos output CW and vpos output CW, current counter values.
REQ-017 SHALL have ports line_start output 1 and frame_start output 1, single-clk pulses.
REQ-018 SHALL have port frame_count output 8, frame counter (see Configuration).

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; the bench SHALL flag an elaboration error if either exceeds 2^CW.
REQ-020 On ce=1: hpos increments, wrapping H_TOTAL-1 -> 0. vpos increments only on that wrap, wrapping V_TOTAL-1 -> 0. On ce=0: counters and syncs hold.
REQ-021 On ce=1, hsync SHALL be registered as active iff the pre-increment hpos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on vpos and the V parameters. Sync therefore lags its count by one ce.
REQ-022 display_on SHALL be combinational: (hpos < H_ACTIVE) and (vpos < V_ACTIVE).
REQ-023 line_start SHALL be high for exactly one clk, the cycle after a ce that wraps hpos to 0, regardless of the ce value in that cycle.
REQ-024 frame_start SHALL be high for exactly one clk, the cycle after a ce that wraps both hpos and vpos to 0; line_start is also high in that cycle.

Reset
REQ-025 With reset=1 at a clk edge: hpos=0, vpos=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_count=0.
REQ-026 Reset SHALL take priority over ce. Reset asserted mid-frame restarts at (0,0) without emitting line_start or frame_start.

Configuration
REQ-027 With macro VTG_FRAME_COUNT_EN defined, frame_count SHALL increment (mod 256) in the same cycle frame_start is asserted.
REQ-028 Without VTG_FRAME_COUNT_EN, frame_count SHALL be constant 0 and no counter register SHALL be instantiated.

Structure
REQ-029 The shared package SHALL hold default 640x480@60 timing constants and a sync-polarity enum.
REQ-030 One sub-module, vtg_axis_counter (a wrapping counter with sync-window compare, instantiated once for H and once for V), is natural.

Verification
REQ-031 Defaults, ce=1 constant, release reset -> hsync low exactly when hpos is 657..752; period 800 clk.
REQ-032 Defaults, ce=1 -> vsync low across lines 491..492 (per REQ-021); frame_start every 420000 clk; display_on high for 307200 clk per frame.
REQ-033 ce toggling 1/0 -> all periods double; line_start is still 1 clk wide.
REQ-034 Reset asserted at hpos=300, vpos=200 -> next cycle hpos=0, vpos=0, syncs inactive, no pulses.
REQ-035 VTG_FRAME_COUNT_EN defined, run 257 frames -> frame_count wraps 255 -> 0 then reads 1; macro undefined -> frame_count stays 0.
REQ-036 HSYNC_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 -> hsync high for hpos 19..21; period 24.
